// File: rtl/kyber_compress_pack_if.sv
// Stream bundle for the Kyber compress/pack block: coefficient-pair input,
// packed 32-bit word output and frame status.
interface kyber_compress_pack_if;
  logic [2:0]  mode;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;

  modport master (
    output mode, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy
  );

  modport slave (
    input  mode, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/kyber_compress_pack.sv
// Streaming Kyber Compress_d (d = 1,4,5,10,11) with LSB-first packing of
// coefficient pairs into 32-bit words; one frame is FRAME_BEATS pairs.
module kyber_compress_pack #(
  parameter int FRAME_BEATS = 128
) (
  input  logic                  clk,
  input  logic                  resetn,
  kyber_compress_pack_if.slave  bus
);

  localparam int BW = $clog2(FRAME_BEATS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(FRAME_BEATS - 1);
  // ceil(2^35 / 3329): exact floor(n/3329) for every n below 2^23
  localparam logic [23:0] RECIP = 24'd10321340;

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

  state_t        state_reg, state_next;
  logic [BW-1:0] beat_cnt_reg;
  logic [6:0]    word_cnt_reg;
  logic [3:0]    d_reg;
  logic          s_valid_reg;
  logic [21:0]   s_data_reg;
  logic [63:0]   buf_reg, buf_next;
  logic [6:0]    fill_reg, fill_next;

  logic          pop, merge, in_ready, in_fire, out_valid, out_last, last_beat;
  logic [6:0]    fill_after_pop;
  logic [3:0]    d_in;
  logic [10:0]   c0, c1;
  logic [21:0]   pair;
  logic [63:0]   shifted;

  function automatic logic [3:0] decode_d(input logic [2:0] m);
    case (m)
      3'd1:    return 4'd4;
      3'd2:    return 4'd5;
      3'd3:    return 4'd10;
      3'd4:    return 4'd11;
      default: return 4'd1;
    endcase
  endfunction

  function automatic logic [10:0] compress(input logic [11:0] x, input logic [3:0] d);
    logic [11:0] xr;
    logic [22:0] num;
    logic [46:0] prod;
    logic [11:0] q;
    logic [11:0] mask;
    xr   = (x >= 12'd3329) ? x - 12'd3329 : x;
    num  = ({11'd0, xr} << d) + 23'd1664;
    prod = {24'd0, num} * {23'd0, RECIP};
    q    = 12'(prod >> 35);
    mask = (12'd1 << d) - 12'd1;
    return 11'(q & mask);
  endfunction

  // A frame's d comes from mode only on beat 0; afterwards the latched copy rules.
  assign d_in = (state_reg == IDLE) ? decode_d(bus.mode) : d_reg;

  always_comb begin
    c0   = compress(bus.in_data[11:0], d_in);
    c1   = compress(bus.in_data[23:12], d_in);
    pair = {11'd0, c0} | ({11'd0, c1} << d_in);
  end

  assign out_valid      = (fill_reg >= 7'd32);
  assign out_last       = out_valid && (word_cnt_reg == ({d_reg, 3'b000} - 7'd1));
  assign pop            = out_valid && bus.out_ready;
  assign fill_after_pop = pop ? fill_reg - 7'd32 : fill_reg;
  assign merge          = s_valid_reg && (fill_after_pop < 7'd32);
  assign last_beat      = (beat_cnt_reg == LAST_BEAT);

  always_comb begin
    state_next = state_reg;
    in_ready   = (state_reg != DRAIN) && (!s_valid_reg || merge);
    in_fire    = bus.in_valid && in_ready;
    case (state_reg)
      IDLE:    if (in_fire) state_next = last_beat ? DRAIN : FILL;
      FILL:    if (in_fire && last_beat) state_next = DRAIN;
      DRAIN:   if (pop && out_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  // Pop first, then append S at the post-pop fill so both can share one edge.
  always_comb begin
    shifted   = pop ? {32'd0, buf_reg[63:32]} : buf_reg;
    buf_next  = shifted;
    fill_next = fill_after_pop;
    if (merge) begin
      buf_next  = shifted | ({42'd0, s_data_reg} << fill_after_pop);
      fill_next = fill_after_pop + {2'b00, d_reg, 1'b0};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      beat_cnt_reg <= '0;
      word_cnt_reg <= '0;
      d_reg        <= '0;
      s_valid_reg  <= 1'b0;
      s_data_reg   <= '0;
      buf_reg      <= '0;
      fill_reg     <= '0;
    end else begin
      if (in_fire && state_reg == IDLE) d_reg <= d_in;
      if (in_fire) beat_cnt_reg <= last_beat ? '0 : beat_cnt_reg + 1'b1;
      if (pop) word_cnt_reg <= out_last ? '0 : word_cnt_reg + 7'd1;
      if (in_fire) begin
        s_valid_reg <= 1'b1;
        s_data_reg  <= pair;
      end else if (merge) begin
        s_valid_reg <= 1'b0;
      end
      buf_reg  <= buf_next;
      fill_reg <= fill_next;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = buf_reg[31:0];
  assign bus.out_last  = out_last;
  assign bus.busy      = (state_reg != IDLE);

endmodule
